// File: rtl/os_rx_monitor.sv
// Ordered-set receiver: decodes SKP/TS1/TS2 from the MAC-side symbol stream,
// captures TS symbols 1-5 and tracks consecutive identical TS1/TS2 counts.
module os_rx_monitor #(
  parameter int unsigned CONSEC_REQ = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_n,
  input  logic [7:0]       rxdata,
  input  logic             rxdatak,
  input  logic             rxvalid,
  input  logic             clr_counts,
  output logic             skp_det,
  output logic             ts1_det,
  output logic             ts2_det,
  output logic             os_err,
  output logic [39:0]      ts_bytes1thru5,
  output logic [CNT_W-1:0] ts1_cnt,
  output logic [CNT_W-1:0] ts2_cnt,
  output logic             ts1_met,
  output logic             ts2_met,
  output logic             in_os
);

  localparam logic [7:0] SYM_COM  = 8'hBC;
  localparam logic [7:0] SYM_SKP  = 8'h1C;
  localparam logic [7:0] TS1_ID   = 8'h4A;
  localparam logic [7:0] TS2_ID   = 8'h45;
  localparam logic [3:0] LAST_IDX = 4'd15;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, HDR, SKP_BODY, TS_BODY} state_t;

  state_t          state;
  logic [3:0]      idx;
  logic [4:0][7:0] shadow;
  logic            ts2_type;

  logic             is_com_c, is_skp_c, ts_ok_c, err_c, ts_done_c, bytes_match_c;
  logic [7:0]       exp_id_c;
  logic [CNT_W-1:0] cnt1_inc_c, cnt2_inc_c, cnt1_nxt_c, cnt2_nxt_c;

  // Symbol classification and error/completion detection for the current symbol
  always_comb begin
    is_com_c = rxdatak && (rxdata == SYM_COM);
    is_skp_c = rxdatak && (rxdata == SYM_SKP);
    exp_id_c = ts2_type ? TS2_ID : TS1_ID;
    if (idx <= 4'd5)
      ts_ok_c = !rxdatak;
    else if (idx == 4'd6)
      ts_ok_c = !rxdatak && ((rxdata == TS1_ID) || (rxdata == TS2_ID));
    else
      ts_ok_c = !rxdatak && (rxdata == exp_id_c);

    err_c = 1'b0;
    if (rxvalid) begin
      case (state)
        HDR:      err_c = rxdatak && !is_com_c && !is_skp_c;
        SKP_BODY: err_c = !is_skp_c;
        TS_BODY:  err_c = !ts_ok_c;
        default:  err_c = 1'b0;
      endcase
    end
    ts_done_c     = rxvalid && (state == TS_BODY) && (idx == LAST_IDX) && ts_ok_c;
    bytes_match_c = (shadow == ts_bytes1thru5);
  end

  // Next consecutive counts; a type mismatch leaves that counter at 0 so +1 yields 1
  always_comb begin
    cnt1_inc_c = (ts1_cnt == CNT_MAX) ? CNT_MAX : ts1_cnt + CNT_W'(1);
    cnt2_inc_c = (ts2_cnt == CNT_MAX) ? CNT_MAX : ts2_cnt + CNT_W'(1);
    cnt1_nxt_c = ts1_cnt;
    cnt2_nxt_c = ts2_cnt;
    if (clr_counts || err_c) begin
      cnt1_nxt_c = '0;
      cnt2_nxt_c = '0;
    end else if (ts_done_c) begin
      if (ts2_type) begin
        cnt1_nxt_c = '0;
        cnt2_nxt_c = bytes_match_c ? cnt2_inc_c : CNT_W'(1);
      end else begin
        cnt1_nxt_c = bytes_match_c ? cnt1_inc_c : CNT_W'(1);
        cnt2_nxt_c = '0;
      end
    end
  end

  assign in_os = (state != IDLE);

  // Parser FSM, captured bytes, counters and pulses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= IDLE;
      idx            <= '0;
      shadow         <= '0;
      ts2_type       <= 1'b0;
      skp_det        <= 1'b0;
      ts1_det        <= 1'b0;
      ts2_det        <= 1'b0;
      os_err         <= 1'b0;
      ts_bytes1thru5 <= '0;
      ts1_cnt        <= '0;
      ts2_cnt        <= '0;
      ts1_met        <= 1'b0;
      ts2_met        <= 1'b0;
    end else if (en_n) begin
      state    <= IDLE;
      idx      <= '0;
      shadow   <= '0;
      ts2_type <= 1'b0;
      skp_det  <= 1'b0;
      ts1_det  <= 1'b0;
      ts2_det  <= 1'b0;
      os_err   <= 1'b0;
      ts1_cnt  <= '0;
      ts2_cnt  <= '0;
      ts1_met  <= 1'b0;
      ts2_met  <= 1'b0;
    end else begin
      skp_det <= 1'b0;
      ts1_det <= 1'b0;
      ts2_det <= 1'b0;
      os_err  <= err_c;
      ts1_cnt <= cnt1_nxt_c;
      ts2_cnt <= cnt2_nxt_c;
      ts1_met <= (32'(cnt1_nxt_c) >= CONSEC_REQ);
      ts2_met <= (32'(cnt2_nxt_c) >= CONSEC_REQ);
      if (rxvalid) begin
        case (state)
          IDLE: begin
            if (is_com_c) state <= HDR;
          end
          HDR: begin
            if (is_com_c) begin
              state <= HDR;
            end else if (is_skp_c) begin
              state <= SKP_BODY;
              idx   <= 4'd2;
            end else if (!rxdatak) begin
              shadow[0] <= rxdata;
              state     <= TS_BODY;
              idx       <= 4'd2;
            end else begin
              state <= IDLE;
            end
          end
          SKP_BODY: begin
            if (is_skp_c) begin
              if (idx == 4'd3) begin
                skp_det <= 1'b1;
                state   <= IDLE;
              end else begin
                idx <= idx + 4'd1;
              end
            end else begin
              state <= is_com_c ? HDR : IDLE;
            end
          end
          TS_BODY: begin
            if (ts_ok_c) begin
              if (idx <= 4'd5) shadow[3'(idx - 4'd1)] <= rxdata;
              if (idx == 4'd6) ts2_type <= (rxdata == TS2_ID);
              if (idx == LAST_IDX) begin
                ts1_det        <= !ts2_type;
                ts2_det        <= ts2_type;
                ts_bytes1thru5 <= shadow;
                state          <= IDLE;
              end else begin
                idx <= idx + 4'd1;
              end
            end else begin
              state <= is_com_c ? HDR : IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_os_rx_monitor.sv
// Scoreboard bench for os_rx_monitor: directed ordered sets with hand-computed
// expected pulses, captured bytes and consecutive counts.
module tb_os_rx_monitor;

  localparam logic [3:0] K_SKP = 4'b1000;
  localparam logic [3:0] K_TS1 = 4'b0100;
  localparam logic [3:0] K_TS2 = 4'b0010;
  localparam logic [3:0] K_ERR = 4'b0001;
  localparam logic [39:0] B1 = 40'h0002FF0201;
  localparam logic [39:0] B3 = 40'h0002FE0201;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en_n = 1'b0;
  logic [7:0]  rxdata = 8'h00;
  logic        rxdatak = 1'b0;
  logic        rxvalid = 1'b0;
  logic        clr_counts = 1'b0;
  logic        skp_det, ts1_det, ts2_det, os_err, ts1_met, ts2_met, in_os;
  logic [39:0] ts_bytes1thru5;
  logic [3:0]  ts1_cnt, ts2_cnt;

  os_rx_monitor #(.CONSEC_REQ(8), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .en_n(en_n), .rxdata(rxdata), .rxdatak(rxdatak),
    .rxvalid(rxvalid), .clr_counts(clr_counts), .skp_det(skp_det),
    .ts1_det(ts1_det), .ts2_det(ts2_det), .os_err(os_err),
    .ts_bytes1thru5(ts_bytes1thru5), .ts1_cnt(ts1_cnt), .ts2_cnt(ts2_cnt),
    .ts1_met(ts1_met), .ts2_met(ts2_met), .in_os(in_os)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  kind;
    logic [39:0] bytes;
    logic [3:0]  c1;
    logic [3:0]  c2;
  } ev_t;

  ev_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;
  logic [7:0] os_sym [16];
  logic       os_k   [16];

  // Monitor: every output pulse must match the oldest expected event
  always @(negedge clk) begin
    if (skp_det || ts1_det || ts2_det || os_err) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event act_kind=%b bytes=%h c1=%0d c2=%0d",
                 {skp_det, ts1_det, ts2_det, os_err}, ts_bytes1thru5, ts1_cnt, ts2_cnt);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if ({skp_det, ts1_det, ts2_det, os_err} !== e.kind || ts_bytes1thru5 !== e.bytes ||
            ts1_cnt !== e.c1 || ts2_cnt !== e.c2 ||
            ts1_met !== (e.c1 >= 4'd8) || ts2_met !== (e.c2 >= 4'd8)) begin
          n_err++;
          $display("FAIL event act kind=%b bytes=%h c1=%0d c2=%0d m1=%b m2=%b exp kind=%b bytes=%h c1=%0d c2=%0d",
                   {skp_det, ts1_det, ts2_det, os_err}, ts_bytes1thru5, ts1_cnt, ts2_cnt,
                   ts1_met, ts2_met, e.kind, e.bytes, e.c1, e.c2);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] k, input logic [39:0] b, input int c1, input int c2);
    ev_t e;
    e.kind = k; e.bytes = b; e.c1 = 4'(c1); e.c2 = 4'(c2);
    sb.push_back(e);
  endtask

  task automatic sym(input logic [7:0] d, input logic k);
    rxdata = d; rxdatak = k; rxvalid = 1'b1;
    @(posedge clk); #1;
    rxvalid = 1'b0;
  endtask

  task automatic build_ts(input logic two, input logic [39:0] b);
    os_sym[0] = 8'hBC; os_k[0] = 1'b1;
    for (int i = 1; i < 16; i++) begin
      os_k[i]   = 1'b0;
      os_sym[i] = (i <= 5) ? b[(i-1)*8 +: 8] : (two ? 8'h45 : 8'h4A);
    end
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) sym(os_sym[i], os_k[i]);
  endtask

  task automatic send_ts(input logic two, input logic [39:0] b, input int c1, input int c2);
    build_ts(two, b);
    push(two ? K_TS2 : K_TS1, b, c1, c2);
    send_range(0, 15);
  endtask

  task automatic send_skp(input logic [39:0] b, input int c1, input int c2);
    push(K_SKP, b, c1, c2);
    sym(8'hBC, 1'b1);
    for (int i = 0; i < 3; i++) sym(8'h1C, 1'b1);
  endtask

  initial begin
    // Reset state, then reset mid-OS discards silently
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pulses", {skp_det, ts1_det, ts2_det, os_err, in_os}, 0);
    chk("rst_bytes", ts_bytes1thru5, 0);
    chk("rst_counts", {ts1_cnt, ts2_cnt, ts1_met, ts2_met}, 0);
    rstn = 1'b1;
    sym(8'hBC, 1'b1); sym(8'h01, 1'b0); sym(8'h02, 1'b0);
    chk("in_os_mid", in_os, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_os", in_os, 0);
    rstn = 1'b1;

    // 8 back-to-back TS1
    for (int i = 1; i <= 8; i++) send_ts(1'b0, B1, i, 0);

    // Clear, then 3 TS1, SKP, 2 TS1
    clr_counts = 1'b1;
    @(posedge clk); #1;
    clr_counts = 1'b0;
    chk("clr_idle", {ts1_cnt, ts1_met}, 0);
    for (int i = 1; i <= 3; i++) send_ts(1'b0, B1, i, 0);
    send_skp(B1, 3, 0);
    send_ts(1'b0, B1, 4, 0);
    send_ts(1'b0, B1, 5, 0);

    // TS1 then TS2 with same bytes, then changed byte 3
    send_ts(1'b0, B1, 6, 0);
    send_ts(1'b1, B1, 0, 1);
    send_ts(1'b1, B3, 0, 1);
    send_ts(1'b1, B3, 0, 2);

    // Bad ID at symbol 9; COM at symbol 12 restarts into a valid TS1
    build_ts(1'b0, B1);
    os_sym[9] = 8'h45;
    push(K_ERR, B3, 0, 0);
    send_range(0, 9);
    build_ts(1'b0, B1);
    os_sym[12] = 8'hBC; os_k[12] = 1'b1;
    push(K_ERR, B3, 0, 0);
    send_range(0, 12);
    chk("com_restart_in_os", in_os, 1);
    build_ts(1'b0, B1);
    push(K_TS1, B1, 1, 0);
    send_range(1, 15);

    // rxvalid stall at idx 7, clr_counts with the final symbol
    build_ts(1'b0, B1);
    send_range(0, 6);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_in_os", in_os, 1);
    send_range(7, 14);
    push(K_TS1, B1, 0, 0);
    clr_counts = 1'b1;
    sym(os_sym[15], os_k[15]);
    clr_counts = 1'b0;
    chk("det_latency", ts1_det, 1);

    // Saturation over 20 identical TS1
    for (int i = 1; i <= 20; i++) send_ts(1'b0, B1, (i > 15) ? 15 : i, 0);
    chk("sat_cnt", {ts1_cnt, ts1_met}, {4'd15, 1'b1});

    // en_n mid-OS: counts cleared, bytes held
    build_ts(1'b0, B1);
    send_range(0, 4);
    en_n = 1'b1;
    @(posedge clk); #1;
    chk("en_n_in_os", in_os, 0);
    chk("en_n_counts", {ts1_cnt, ts2_cnt, ts1_met, ts2_met}, 0);
    chk("en_n_bytes", ts_bytes1thru5, B1);
    en_n = 1'b0;
    send_ts(1'b0, B1, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 0);
    chk("final_idle", in_os, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/os_rx_monitor.md
Name: os_rx_monitor

Overview:
- MAC-side ordered-set receiver directly downstream of the PHY-to-MAC driver.
- Consumes the byte stream on rxdata/rxdatak/rxvalid and decodes SKP (COM+3×SKP), TS1 and TS2 (16 symbols) ordered sets.
- Captures TS symbols 1-5 and counts consecutive identical TS1/TS2 so the LTSSM can qualify state transitions (e.g. 8 consecutive TS1 in POLLING_ACTIVE).

Parameters:
CONSEC_REQ, 8, consecutive identical TS count that asserts the *_met flag
CNT_W, 4, width of the consecutive counters; they saturate at 2^CNT_W-1

Ports:
clk  input  1  clock; all logic on its rising edge
rstn  input  1  synchronous, active-low reset
en_n  input  1  active-low enable; high forces IDLE and clears counts
rxdata  input  8  received symbol
rxdatak  input  1  1 = rxdata is a K symbol
rxvalid  input  1  symbol qualifier; low = no symbol this cycle
clr_counts  input  1  pulse from LTSSM on state change; clears both counters
skp_det  output  1  1-cycle pulse: valid SKP OS received
ts1_det  output  1  1-cycle pulse: valid TS1 received
ts2_det  output  1  1-cycle pulse: valid TS2 received
os_err  output  1  1-cycle pulse: malformed OS aborted
ts_bytes1thru5  output  40  symbols 1-5 of last valid TS, symbol 1 in [7:0], symbol 5 in [39:32]
ts1_cnt  output  CNT_W  consecutive identical TS1 count
ts2_cnt  output  CNT_W  consecutive identical TS2 count
ts1_met  output  1  ts1_cnt >= CONSEC_REQ
ts2_met  output  1  ts2_cnt >= CONSEC_REQ
in_os  output  1  FSM is not in IDLE

Behaviour:
- Symbol codes: COM = K 8'hBC, SKP = K 8'h1C, TS1ID = D 8'h4A, TS2ID = D 8'h45.
- A symbol is consumed only when rxvalid=1. rxvalid=0 stalls the FSM and index with no timeout.
- Reset (rstn=0 at clk edge): FSM=IDLE, all pulses 0, ts_bytes1thru5=0, counts 0, met 0, in_os 0.
- Reset mid-OS discards the partial OS without an os_err pulse.
- en_n=1 behaves like reset, except ts_bytes1thru5 holds its value.
- FSM states: IDLE, HDR, SKP_BODY, TS_BODY.
  - IDLE: K COM -> HDR. Any other symbol is ignored (no error).
  - HDR (symbol 1):
    - K SKP -> SKP_BODY with idx=2.
    - D symbol -> stored in shadow[0], go to TS_BODY with idx=2.
    - K COM -> stay in HDR (restart).
    - Other K -> os_err, go to IDLE.
  - SKP_BODY: requires K SKP at idx 2 and 3. At idx 3 -> skp_det, go to IDLE.
  - TS_BODY, idx 2-5: D symbol stored in shadow[idx-1].
  - TS_BODY, idx 6: D TS1ID or TS2ID; the value latches the type.
  - TS_BODY, idx 7-15: D symbol equal to the latched ID.
  - TS_BODY, at idx 15: fire the matching ts*_det, copy shadow to ts_bytes1thru5, go to IDLE.
- Any violation in SKP_BODY/TS_BODY (wrong symbol or wrong K flag): os_err pulse.
  - If the offending symbol is K COM, next state is HDR; otherwise IDLE.
- Latency: *_det, os_err and ts_bytes1thru5 update on the edge that samples the last (or offending) symbol, i.e. visible the cycle after that symbol is presented.
- Consecutive counting, evaluated when a TS completes:
  - Same type as the previous valid TS and shadow == ts_bytes1thru5 (pre-update): that counter += 1, saturating at 2^CNT_W-1.
  - Otherwise: that counter = 1.
  - In both cases the other-type counter = 0.
- SKP OS does not affect counters. os_err clears both counters.
- clr_counts has priority: counters go to 0 even if a TS completes in the same cycle. The det pulse and ts_bytes update still occur.
- ts1_met/ts2_met are registered compares of the counters; they update in the same cycle as the counters.
- in_os is combinational from FSM state.

Test Plan:
- Reset then 8 back-to-back TS1 with bytes1-5 = 01,02,FF,02,00 -> 8 ts1_det pulses; ts1_cnt 1..8; ts1_met rises with the 8th; ts_bytes1thru5=40'h0002FF0201.
- 3 TS1, one SKP OS, 2 TS1 (same bytes) -> skp_det once; ts1_cnt ends at 5; os_err never asserts.
- TS1 then TS2 with identical bytes1-5 -> ts1_cnt=0, ts2_cnt=1 after the TS2; then TS2 with byte 3 changed -> ts2_cnt=1.
- TS1 whose symbol 9 is 8'h45, followed by K COM at symbol 12 of the next OS -> os_err per violation; COM restart parses a following valid TS1 correctly (ts1_cnt=1).
- TS1 with rxvalid dropped for 5 cycles at idx 7, then resumed -> ts1_det exactly once, 1 cycle after symbol 15; clr_counts on that same cycle -> ts1_cnt=0.
- 20 identical TS1 -> ts1_cnt saturates at 15; en_n=1 mid-OS -> counts 0, in_os 0, ts_bytes held.
